// File: rtl/mpc_inflight_tracker_pkg.sv
// Shared types and configuration helpers for the in-flight refill tracker.
// Cache geometry is carried as a packed config struct built from user-level settings.
package mpc_inflight_tracker_pkg;

    typedef struct packed {
        int unsigned sets;
        int unsigned ways;
        int unsigned clWidth;
        int unsigned clWordWidth;
    } mpc_user_cfg_t;

    typedef struct packed {
        int unsigned sets;
        int unsigned ways;
        int unsigned setWidth;
        int unsigned wayIndexWidth;
        int unsigned nlineWidth;
        int unsigned clWidth;
        int unsigned clWordWidth;
    } mpc_cfg_t;

    localparam mpc_user_cfg_t MpcDefaultUserCfg = '{
        sets: 8, ways: 4, clWidth: 128, clWordWidth: 64
    };

    typedef enum logic [1:0] {
        IFL_IDLE = 2'd0,
        IFL_PEND = 2'd1,
        IFL_FILL = 2'd2
    } inflight_state_e;

    function automatic mpc_cfg_t mpcBuildConfig(input mpc_user_cfg_t u);
        mpc_cfg_t c;
        c.sets          = u.sets;
        c.ways          = u.ways;
        c.setWidth      = (u.sets > 1) ? $clog2(u.sets) : 1;
        c.wayIndexWidth = (u.ways > 1) ? $clog2(u.ways) : 1;
        c.nlineWidth    = c.setWidth + c.wayIndexWidth;
        c.clWidth       = u.clWidth;
        c.clWordWidth   = u.clWordWidth;
        return c;
    endfunction

    // A line narrower than one memctl word still takes a single beat.
    function automatic int mpcBeatsPerLine(input mpc_cfg_t c);
        if (c.clWordWidth == 0 || c.clWidth <= c.clWordWidth) return 1;
        return int'(c.clWidth / c.clWordWidth);
    endfunction

endpackage

// File: rtl/mpc_inflight_tracker_if.sv
// Bundle of HTU allocation/lookup and memctl refill signals around the tracker.
// master drives requests and beats; slave is the tracker itself.
interface mpc_inflight_tracker_if #(
    parameter int SetW      = 3,
    parameter int WayW      = 2,
    parameter int NumLookup = 2,
    parameter int CntW      = 3
);
    localparam int NlineW = SetW + WayW;

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [SetW-1:0]      alloc_set;
    logic [WayW-1:0]      alloc_way;
    logic [SetW-1:0]      lookup_set [NumLookup];
    logic [WayW-1:0]      lookup_way [NumLookup];
    logic [NumLookup-1:0] inflight_flg;
    logic                 memctl_refill_valid;
    logic [NlineW-1:0]    memctl_refill_id;
    logic                 refill_done_valid;
    logic [NlineW-1:0]    refill_done_id;
    logic [CntW-1:0]      outstanding_cnt;
    logic                 err_dup_alloc;
    logic                 err_stray_beat;

    modport master (
        output alloc_valid, alloc_set, alloc_way, lookup_set, lookup_way,
               memctl_refill_valid, memctl_refill_id,
        input  alloc_ready, inflight_flg, refill_done_valid, refill_done_id,
               outstanding_cnt, err_dup_alloc, err_stray_beat
    );

    modport slave (
        input  alloc_valid, alloc_set, alloc_way, lookup_set, lookup_way,
               memctl_refill_valid, memctl_refill_id,
        output alloc_ready, inflight_flg, refill_done_valid, refill_done_id,
               outstanding_cnt, err_dup_alloc, err_stray_beat
    );

endinterface

// File: rtl/mpc_inflight_tracker_entry.sv
// State of one cache line's refill: IDLE/PEND/FILL plus a beat counter.
// done/err outputs are registered one-cycle pulses; fin_o flags the final beat combinationally.
module mpc_inflight_tracker_entry
    import mpc_inflight_tracker_pkg::*;
#(
    parameter int BeatsPerLine = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic alloc_i,
    input  logic beat_i,
    output logic busy_o,
    output logic fin_o,
    output logic done_o,
    output logic err_dup_o,
    output logic err_stray_o
);
    localparam int              BeatW    = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerLine - 1);

    inflight_state_e  state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic             done_q, done_d;
    logic             dup_q, dup_d;
    logic             stray_q, stray_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IFL_IDLE;
            beat_q  <= '0;
            done_q  <= 1'b0;
            dup_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            dup_q   <= dup_d;
            stray_q <= stray_d;
        end
    end

    // An alloc and a beat in the same cycle are both judged against the current state.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        dup_d   = 1'b0;
        stray_d = 1'b0;
        fin_o   = 1'b0;
        unique case (state_q)
            IFL_IDLE: begin
                if (alloc_i) state_d = IFL_PEND;
                if (beat_i)  stray_d = 1'b1;
            end
            IFL_PEND, IFL_FILL: begin
                if (alloc_i) dup_d = 1'b1;
                if (beat_i) begin
                    if (beat_q == LastBeat) begin
                        fin_o   = 1'b1;
                        beat_d  = '0;
                        state_d = IFL_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d  = beat_q + BeatW'(1);
                        state_d = IFL_FILL;
                    end
                end
            end
            default: begin
                state_d = IFL_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    assign busy_o      = (state_q != IFL_IDLE);
    assign done_o      = done_q;
    assign err_dup_o   = dup_q;
    assign err_stray_o = stray_q;

endmodule

// File: rtl/mpc_inflight_tracker.sv
// Tracks every (set,way) with an outstanding memctl refill so the HTU can stall hits on it.
// One entry per line, N combinational lookup ports, bounded outstanding count with backpressure.
module mpc_inflight_tracker
    import mpc_inflight_tracker_pkg::*;
#(
    parameter mpc_cfg_t Cfg             = mpcBuildConfig(MpcDefaultUserCfg),
    parameter type      setWidth_t      = logic [Cfg.setWidth-1:0],
    parameter type      wayIndexWidth_t = logic [Cfg.wayIndexWidth-1:0],
    parameter type      nlineWidth_t    = logic [Cfg.nlineWidth-1:0],
    parameter int       NumLookup       = 2,
    parameter int       MaxOutstanding  = 4,
    parameter int       BeatsPerLine    = mpcBeatsPerLine(Cfg)
) (
    input logic                   clk,
    input logic                   rst,
    mpc_inflight_tracker_if.slave bus
);
    localparam int Sets       = int'(Cfg.sets);
    localparam int Ways       = int'(Cfg.ways);
    localparam int SetW       = int'(Cfg.setWidth);
    localparam int NlineW     = int'(Cfg.nlineWidth);
    localparam int NumEntries = Sets * Ways;
    localparam int CntW       = $clog2(MaxOutstanding + 1);

    logic [NumEntries-1:0]                ent_alloc, ent_beat;
    logic [NumEntries-1:0]                busy, fin, done, err_dup, err_stray;
    logic [NumLookup-1:0][NumEntries-1:0] hit;
    logic [NlineW-1:0][NumEntries-1:0]    id_mask;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic                                 alloc_fire, alloc_new, fin_any;
    nlineWidth_t                          beat_id;
    setWidth_t                            beat_set;
    wayIndexWidth_t                       beat_way;

    // Ready depends only on the registered count, so a completion frees the slot one cycle later.
    assign bus.alloc_ready = (cnt_q < CntW'(MaxOutstanding));
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

    assign beat_id  = bus.memctl_refill_id;
    assign beat_set = beat_id[SetW-1:0];
    assign beat_way = beat_id[NlineW-1:SetW];

    for (genvar gw = 0; gw < Ways; gw++) begin : g_way
        for (genvar gs = 0; gs < Sets; gs++) begin : g_set
            localparam int          Idx     = gw * Sets + gs;
            localparam nlineWidth_t EntryId = {wayIndexWidth_t'(gw), setWidth_t'(gs)};

            assign ent_alloc[Idx] = alloc_fire
                                    && (bus.alloc_way == wayIndexWidth_t'(gw))
                                    && (bus.alloc_set == setWidth_t'(gs));
            assign ent_beat[Idx]  = bus.memctl_refill_valid
                                    && (beat_way == wayIndexWidth_t'(gw))
                                    && (beat_set == setWidth_t'(gs));

            mpc_inflight_tracker_entry #(
                .BeatsPerLine(BeatsPerLine)
            ) u_entry (
                .clk        (clk),
                .rst        (rst),
                .alloc_i    (ent_alloc[Idx]),
                .beat_i     (ent_beat[Idx]),
                .busy_o     (busy[Idx]),
                .fin_o      (fin[Idx]),
                .done_o     (done[Idx]),
                .err_dup_o  (err_dup[Idx]),
                .err_stray_o(err_stray[Idx])
            );

            for (genvar gp = 0; gp < NumLookup; gp++) begin : g_hit
                assign hit[gp][Idx] = busy[Idx]
                                      && (bus.lookup_way[gp] == wayIndexWidth_t'(gw))
                                      && (bus.lookup_set[gp] == setWidth_t'(gs));
            end

            // At most one entry completes per cycle, so OR-ing masked ids is a one-hot mux.
            for (genvar gb = 0; gb < NlineW; gb++) begin : g_id
                assign id_mask[gb][Idx] = done[Idx] & EntryId[gb];
            end
        end
    end

    for (genvar gp = 0; gp < NumLookup; gp++) begin : g_lookup
        assign bus.inflight_flg[gp] = |hit[gp];
    end

    for (genvar gb = 0; gb < NlineW; gb++) begin : g_done_id
        assign bus.refill_done_id[gb] = |id_mask[gb];
    end

    assign bus.refill_done_valid = |done;
    assign bus.err_dup_alloc     = |err_dup;
    assign bus.err_stray_beat    = |err_stray;

    // Only allocs into idle entries add to the count; the count equals the number of busy entries.
    assign alloc_new = |(ent_alloc & ~busy);
    assign fin_any   = |fin;

    always_comb begin
        cnt_d = cnt_q;
        if (alloc_new && !fin_any)      cnt_d = cnt_q + CntW'(1);
        else if (!alloc_new && fin_any) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.outstanding_cnt = cnt_q;

endmodule

// File: tb/tb_mpc_inflight_tracker.sv
// Scenario bench for the in-flight tracker: 8 sets x 4 ways, 2 beats per line, 4 outstanding.
// Completed line ids are queued when the final beat is driven and checked when the done pulse appears.
module tb_mpc_inflight_tracker;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [4:0] sb [$];
    logic [4:0] exp_id;

    mpc_inflight_tracker_if #(.SetW(3), .WayW(2), .NumLookup(2), .CntW(3)) bus ();

    mpc_inflight_tracker #(
        .NumLookup     (2),
        .MaxOutstanding(4),
        .BeatsPerLine  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Done pulses are consumed from the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (!rst && bus.refill_done_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected got_id=%0d exp=none", bus.refill_done_id);
            end else begin
                exp_id = sb.pop_front();
                if (bus.refill_done_id !== exp_id) begin
                    bad++;
                    $display("FAIL done_id got=%0d exp=%0d", bus.refill_done_id, exp_id);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [2:0] s, input logic [1:0] w);
        bus.alloc_set   = s;
        bus.alloc_way   = w;
        bus.alloc_valid = 1'b1;
        step();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic beat(input logic [4:0] id, input bit last);
        bus.memctl_refill_id    = id;
        bus.memctl_refill_valid = 1'b1;
        if (last) sb.push_back(id);
        step();
        bus.memctl_refill_valid = 1'b0;
    endtask

    task automatic probe(input logic [2:0] s0, input logic [1:0] w0,
                         input logic [2:0] s1, input logic [1:0] w1);
        bus.lookup_set[0] = s0;
        bus.lookup_way[0] = w0;
        bus.lookup_set[1] = s1;
        bus.lookup_way[1] = w1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.alloc_ready); end
        total++; if (bus.inflight_flg !== 2'b00) begin bad++; $display("FAIL reset_flg got=%b exp=00", bus.inflight_flg); end
        total++; if (bus.refill_done_valid !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.refill_done_valid); end
        total++; if (bus.refill_done_id !== 5'd0) begin bad++; $display("FAIL reset_done_id got=%0d exp=0", bus.refill_done_id); end
        total++; if (bus.outstanding_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.outstanding_cnt); end
        total++; if ({bus.err_dup_alloc, bus.err_stray_beat} !== 2'b00) begin
            bad++; $display("FAIL reset_err got=%b exp=00", {bus.err_dup_alloc, bus.err_stray_beat});
        end
        rst = 1'b0;
        step();
        total++; if (bus.outstanding_cnt !== 3'd0 || bus.alloc_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset cnt=%0d ready=%b exp cnt=0 ready=1", bus.outstanding_cnt, bus.alloc_ready);
        end
    endtask

    task automatic test_basic();
        probe(3'd1, 2'd2, 3'd0, 2'd0);
        alloc(3'd1, 2'd2);
        total++; if (bus.inflight_flg[0] !== 1'b1 || bus.outstanding_cnt !== 3'd1) begin
            bad++; $display("FAIL basic_alloc flg=%b cnt=%0d exp flg=1 cnt=1", bus.inflight_flg[0], bus.outstanding_cnt);
        end
        beat(5'd17, 1'b0);
        total++; if (bus.inflight_flg[0] !== 1'b1 || bus.refill_done_valid !== 1'b0) begin
            bad++; $display("FAIL basic_beat1 flg=%b done=%b exp flg=1 done=0", bus.inflight_flg[0], bus.refill_done_valid);
        end
        beat(5'd17, 1'b1);
        total++; if (bus.inflight_flg[0] !== 1'b0 || bus.outstanding_cnt !== 3'd0) begin
            bad++; $display("FAIL basic_final flg=%b cnt=%0d exp flg=0 cnt=0", bus.inflight_flg[0], bus.outstanding_cnt);
        end
        total++; if (bus.refill_done_valid !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", bus.refill_done_valid); end
        step();
        total++; if (bus.refill_done_valid !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", bus.refill_done_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) alloc(3'(i), 2'd0);
        total++; if (bus.alloc_ready !== 1'b0 || bus.outstanding_cnt !== 3'd4) begin
            bad++; $display("FAIL full_state ready=%b cnt=%0d exp ready=0 cnt=4", bus.alloc_ready, bus.outstanding_cnt);
        end
        probe(3'd4, 2'd0, 3'd3, 2'd0);
        alloc(3'd4, 2'd0);
        total++; if (bus.inflight_flg !== 2'b10 || bus.outstanding_cnt !== 3'd4) begin
            bad++; $display("FAIL full_blocked flg=%b cnt=%0d exp flg=10 cnt=4", bus.inflight_flg, bus.outstanding_cnt);
        end
        beat(5'd0, 1'b0);
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready_early got=%b exp=0", bus.alloc_ready); end
        beat(5'd0, 1'b1);
        total++; if (bus.alloc_ready !== 1'b1 || bus.outstanding_cnt !== 3'd3) begin
            bad++; $display("FAIL full_release ready=%b cnt=%0d exp ready=1 cnt=3", bus.alloc_ready, bus.outstanding_cnt);
        end
        for (int i = 1; i < 4; i++) begin
            beat(5'(i), 1'b0);
            beat(5'(i), 1'b1);
        end
        total++; if (bus.outstanding_cnt !== 3'd0) begin bad++; $display("FAIL full_drain cnt=%0d exp=0", bus.outstanding_cnt); end
    endtask

    task automatic test_simultaneous();
        probe(3'd2, 2'd3, 3'd1, 2'd2);
        alloc(3'd1, 2'd2);
        beat(5'd17, 1'b0);
        bus.alloc_set   = 3'd2;
        bus.alloc_way   = 2'd3;
        bus.alloc_valid = 1'b1;
        beat(5'd17, 1'b1);
        bus.alloc_valid = 1'b0;
        total++; if (bus.outstanding_cnt !== 3'd1 || bus.inflight_flg !== 2'b01) begin
            bad++; $display("FAIL simul_diff cnt=%0d flg=%b exp cnt=1 flg=01", bus.outstanding_cnt, bus.inflight_flg);
        end
        beat(5'd26, 1'b0);
        // Same line: alloc sees a busy entry and is a duplicate, the beat still completes it.
        bus.alloc_set   = 3'd2;
        bus.alloc_way   = 2'd3;
        bus.alloc_valid = 1'b1;
        beat(5'd26, 1'b1);
        bus.alloc_valid = 1'b0;
        total++; if (bus.err_dup_alloc !== 1'b1 || bus.outstanding_cnt !== 3'd0 || bus.inflight_flg[0] !== 1'b0) begin
            bad++; $display("FAIL simul_same dup=%b cnt=%0d flg=%b exp dup=1 cnt=0 flg=0",
                            bus.err_dup_alloc, bus.outstanding_cnt, bus.inflight_flg[0]);
        end
    endtask

    task automatic test_errors();
        alloc(3'd1, 2'd2);
        alloc(3'd1, 2'd2);
        total++; if (bus.err_dup_alloc !== 1'b1 || bus.outstanding_cnt !== 3'd1) begin
            bad++; $display("FAIL err_dup dup=%b cnt=%0d exp dup=1 cnt=1", bus.err_dup_alloc, bus.outstanding_cnt);
        end
        step();
        total++; if (bus.err_dup_alloc !== 1'b0) begin bad++; $display("FAIL err_dup_pulse got=%b exp=0", bus.err_dup_alloc); end
        beat(5'd5, 1'b0);
        total++; if (bus.err_stray_beat !== 1'b1 || bus.outstanding_cnt !== 3'd1) begin
            bad++; $display("FAIL err_stray stray=%b cnt=%0d exp stray=1 cnt=1", bus.err_stray_beat, bus.outstanding_cnt);
        end
        beat(5'd17, 1'b0);
        total++; if (bus.err_stray_beat !== 1'b0) begin bad++; $display("FAIL err_stray_pulse got=%b exp=0", bus.err_stray_beat); end
        beat(5'd17, 1'b1);
    endtask

    task automatic test_multiport();
        probe(3'd1, 2'd2, 3'd2, 2'd3);
        alloc(3'd1, 2'd2);
        total++; if (bus.inflight_flg !== 2'b01) begin bad++; $display("FAIL mport_flg got=%b exp=01", bus.inflight_flg); end
        probe(3'd2, 2'd3, 3'd1, 2'd2);
        #1;
        total++; if (bus.inflight_flg !== 2'b10) begin bad++; $display("FAIL mport_swap got=%b exp=10", bus.inflight_flg); end
        beat(5'd17, 1'b0);
        beat(5'd17, 1'b1);
        total++; if (bus.inflight_flg !== 2'b00) begin bad++; $display("FAIL mport_clear got=%b exp=00", bus.inflight_flg); end
    endtask

    task automatic test_reset_mid();
        probe(3'd1, 2'd2, 3'd1, 2'd2);
        alloc(3'd1, 2'd2);
        beat(5'd17, 1'b0);
        rst = 1'b1;
        #2;
        total++; if (bus.inflight_flg !== 2'b00 || bus.outstanding_cnt !== 3'd0 || bus.alloc_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_state flg=%b cnt=%0d ready=%b exp flg=00 cnt=0 ready=1",
                            bus.inflight_flg, bus.outstanding_cnt, bus.alloc_ready);
        end
        step();
        rst = 1'b0;
        beat(5'd17, 1'b0);
        total++; if (bus.err_stray_beat !== 1'b1 || bus.refill_done_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_stray stray=%b done=%b exp stray=1 done=0", bus.err_stray_beat, bus.refill_done_valid);
        end
    endtask

    initial begin
        rst                     = 1'b1;
        bus.alloc_valid         = 1'b0;
        bus.alloc_set           = '0;
        bus.alloc_way           = '0;
        bus.memctl_refill_valid = 1'b0;
        bus.memctl_refill_id    = '0;
        probe(3'd0, 2'd0, 3'd0, 2'd0);
        test_reset();
        test_basic();
        test_full();
        test_simultaneous();
        test_errors();
        test_multiport();
        test_reset_mid();
        step();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain pending=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
